// File: rtl/reg_file.sv
// 32-entry RV32I integer register file: two combinational read ports, one clocked
// write port, x0 hardwired to zero, and write-first bypass from the writeback port.
module reg_file #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [N-1:0]      write_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [N-1:0]      read_data1,
  output logic [N-1:0]      read_data2
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 has no storage; the array starts at index 1.
  logic [N-1:0] entry_reg [1:DEPTH-1];

  logic write_en;
  assign write_en = RegWrite && (rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (write_en) begin
      entry_reg[rd] <= write_data;
    end
  end

  // Flatten the array so each read port can use a plain indexed select,
  // with slot 0 tied to zero instead of reaching outside the array bounds.
  logic [N-1:0] entry_view [0:DEPTH-1];

  assign entry_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_view
      assign entry_view[gi] = entry_reg[gi];
    end
  endgenerate

  // Bypass only fires for a real write (rd != 0) and is suppressed during reset.
  logic bypass1;
  logic bypass2;
  assign bypass1 = write_en && (rd == rs1);
  assign bypass2 = write_en && (rd == rs2);

  always_comb begin
    read_data1 = '0;
    if (!rst && (rs1 != '0)) begin
      read_data1 = bypass1 ? write_data : entry_view[rs1];
    end
  end

  always_comb begin
    read_data2 = '0;
    if (!rst && (rs2 != '0)) begin
      read_data2 = bypass2 ? write_data : entry_view[rs2];
    end
  end

endmodule
